// File: rtl/catch_game_scheduler_if.sv
// Game-side bundle: VSync/start/paddle in, block overlay and score/lives out.
interface catch_game_scheduler_if;
  logic       iVSync;
  logic       iStart;
  logic [9:0] iPaddleX;
  logic [9:0] oBlockX;
  logic [9:0] oBlockY;
  logic       oBlockValid;
  logic [7:0] oScore;
  logic [2:0] oLives;
  logic       oGameOver;
  logic [2:0] oState;

  modport master (
    output iVSync, iStart, iPaddleX,
    input  oBlockX, oBlockY, oBlockValid, oScore, oLives, oGameOver, oState
  );

  modport slave (
    input  iVSync, iStart, iPaddleX,
    output oBlockX, oBlockY, oBlockValid, oScore, oLives, oGameOver, oState
  );
endinterface

// File: rtl/catch_game_scheduler.sv
// Frame-rate catch game sequencer: steps a falling block on VSync edges,
// tests it against the paddle and keeps score and lives.
module catch_game_scheduler #(
  parameter int FRAMES_PER_STEP = 2,
  parameter int STEP            = 4,
  parameter int PADDLE_Y        = 400,
  parameter int FLOOR_Y         = 416,
  parameter int BLOCK_W         = 16,
  parameter int PADDLE_W        = 48,
  parameter int X_MIN           = 224,
  parameter int LIVES           = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  catch_game_scheduler_if.slave  bus
);

  // Counter is at least one bit wide so FRAMES_PER_STEP=1 still elaborates.
  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    CHECK = 3'd3,
    CATCH = 3'd4,
    MISS  = 3'd5,
    OVER  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            valid_q, valid_d;
  logic [7:0]      score_q, score_d;
  logic [2:0]      lives_q, lives_d;
  logic            over_q, over_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      lfsr_q;
  logic            vs_q;

  logic            tick;
  logic            lfsr_fb;
  logic            hit;
  logic            floor_hit;
  logic [10:0]     y_bot, x_rt, p_rt;

  // x^8+x^6+x^5+x^4+1 taps; a nonzero seed never reaches zero.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Falling edge of the registered VSync marks one frame.
  assign tick = vs_q & ~bus.iVSync;

  // Overlap in 11 bits so the right edges can't wrap past 1023.
  assign y_bot     = {1'b0, y_q} + 11'(BLOCK_W);
  assign x_rt      = {1'b0, x_q} + 11'(BLOCK_W);
  assign p_rt      = {1'b0, bus.iPaddleX} + 11'(PADDLE_W);
  assign hit       = (y_bot >= 11'(PADDLE_Y)) && (x_rt > {1'b0, bus.iPaddleX}) &&
                     ({1'b0, x_q} < p_rt);
  assign floor_hit = ({1'b0, y_q} >= 11'(FLOOR_Y));

  // State, game registers, LFSR and VSync history.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      x_q     <= 10'(X_MIN);
      y_q     <= '0;
      valid_q <= 1'b0;
      score_q <= '0;
      lives_q <= 3'(LIVES);
      over_q  <= 1'b0;
      cnt_q   <= '0;
      lfsr_q  <= 8'hA5;
      vs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      score_q <= score_d;
      lives_q <= lives_d;
      over_q  <= over_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= {lfsr_q[6:0], lfsr_fb};
      vs_q    <= bus.iVSync;
    end
  end

  // Next-state and next-value logic for the game sequence.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = valid_q;
    score_d = score_q;
    lives_d = lives_q;
    over_d  = over_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (bus.iStart) begin
          state_d = SPAWN;
          score_d = '0;
          lives_d = 3'(LIVES);
        end
      end
      SPAWN: begin
        x_d     = 10'(X_MIN) + {2'b00, lfsr_q[4:0], 3'b000};
        y_d     = '0;
        cnt_d   = '0;
        valid_d = 1'b1;
        state_d = FALL;
      end
      FALL: begin
        if (tick) begin
          if (cnt_q == CW'(FRAMES_PER_STEP - 1)) begin
            cnt_d   = '0;
            y_d     = y_q + 10'(STEP);
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CHECK: begin
        if (hit)            state_d = CATCH;
        else if (floor_hit) state_d = MISS;
        else                state_d = FALL;
      end
      CATCH: begin
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        valid_d = 1'b0;
        state_d = SPAWN;
      end
      MISS: begin
        valid_d = 1'b0;
        if (lives_q == 3'd1) begin
          lives_d = '0;
          over_d  = 1'b1;
          state_d = OVER;
        end else begin
          lives_d = lives_q - 3'd1;
          state_d = SPAWN;
        end
      end
      OVER: begin
        over_d  = 1'b1;
        valid_d = 1'b0;
        if (bus.iStart) begin
          over_d  = 1'b0;
          score_d = '0;
          lives_d = 3'(LIVES);
          state_d = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.oBlockX     = x_q;
  assign bus.oBlockY     = y_q;
  assign bus.oBlockValid = valid_q;
  assign bus.oScore      = score_q;
  assign bus.oLives      = lives_q;
  assign bus.oGameOver   = over_q;
  assign bus.oState      = state_q;

endmodule

// File: tb/tb_catch_game_scheduler.sv
// Directed bench for catch_game_scheduler: spawn, fall, catch, miss,
// game over, async reset and score saturation.
module tb_catch_game_scheduler;

  localparam int S_IDLE = 0, S_SPAWN = 1, S_FALL = 2, S_CHECK = 3,
                 S_CATCH = 4, S_MISS = 5, S_OVER = 6;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  catch_game_scheduler_if b();
  catch_game_scheduler_if b2();

  catch_game_scheduler dut (.Clock(Clock), .Reset(Reset), .bus(b));

  // Fast-catch instance: one frame per step, paddle spans every X, low paddle line.
  catch_game_scheduler #(.FRAMES_PER_STEP(1), .PADDLE_Y(20), .PADDLE_W(600)) dut2 (
    .Clock(Clock), .Reset(Reset), .bus(b2));

  always #5 Clock = ~Clock;

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR, advancing with the DUT's clock.
  logic [7:0] m_lfsr;
  always @(posedge Clock or posedge Reset)
    if (Reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= lstep(m_lfsr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clock);
  endtask

  logic [2:0] s1, s2;
  logic [9:0] y1;

  // One VSync falling edge; s1/y1 one cycle after the tick, s2 one cycle later.
  task automatic frame();
    b.iVSync = 1'b0;
    cyc();
    s1 = b.oState;
    y1 = b.oBlockY;
    b.iVSync = 1'b1;
    cyc();
    s2 = b.oState;
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic do_reset();
    cyc();
    Reset = 1'b1;
    b.iVSync = 1'b1;
    b.iStart = 1'b0;
    cyc();
    Reset = 1'b0;
  endtask

  // Start so that the SPAWN cycle sees LFSR[4:0]==0, giving X=X_MIN.
  task automatic seeded_start();
    logic [7:0] t;
    int k;
    k = 0;
    t = lstep(m_lfsr);
    while (t[4:0] != 5'd0 && k < 300) begin
      cyc();
      t = lstep(m_lfsr);
      k++;
    end
    chk("seed_found", 32'(k < 300), 1);
    b.iStart = 1'b1;
    cyc();
    b.iStart = 1'b0;
    chk("seed_spawn", b.oState, S_SPAWN);
    cyc();
    chk("seed_fall", b.oState, S_FALL);
    chk("seed_x", b.oBlockX, 224);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, b.oState, S_IDLE);
    chk({tag, "_x"}, b.oBlockX, 224);
    chk({tag, "_y"}, b.oBlockY, 0);
    chk({tag, "_valid"}, b.oBlockValid, 0);
    chk({tag, "_score"}, b.oScore, 0);
    chk({tag, "_lives"}, b.oLives, 3);
    chk({tag, "_over"}, b.oGameOver, 0);
  endtask

  initial begin
    b2.iVSync = 1'b1;
    forever begin
      repeat (4) @(negedge Clock);
      b2.iVSync = ~b2.iVSync;
    end
  end

  initial begin
    logic [9:0] ex;
    int k;
    b.iVSync = 1'b1;
    b.iStart = 1'b0;
    b.iPaddleX = 10'd0;
    b2.iStart = 1'b0;
    b2.iPaddleX = 10'd0;

    // Reset state, and a frame in IDLE is ignored.
    do_reset();
    chk_reset_vals("rst");
    frame();
    chk("idle_tick_s2", s2, S_IDLE);

    // Random spawn from the LFSR, then six frames with iStart held high.
    b.iStart = 1'b1;
    cyc();
    chk("t1_spawn", b.oState, S_SPAWN);
    chk("t1_lives", b.oLives, 3);
    chk("t1_score", b.oScore, 0);
    ex = 10'd224 + {2'b00, m_lfsr[4:0], 3'b000};
    cyc();
    chk("t1_fall", b.oState, S_FALL);
    chk("t1_x", b.oBlockX, ex);
    chk("t1_y0", b.oBlockY, 0);
    chk("t1_valid", b.oBlockValid, 1);
    for (int i = 1; i <= 6; i++) begin
      frame();
      if (i % 2 == 0) begin
        chk("t1_check", s1, S_CHECK);
        chk("t1_yup", y1, 32'(2 * i));
      end else begin
        chk("t1_hold", s1, S_FALL);
      end
      chk("t1_back", s2, S_FALL);
    end
    b.iStart = 1'b0;
    chk("t1_y12", b.oBlockY, 12);
    chk("t1_score_kept", b.oScore, 0);

    // Catch: paddle right under the block, hit once Y reaches 384.
    do_reset();
    b.iPaddleX = 10'd224;
    seeded_start();
    frames(191);
    chk("c_y380", b.oBlockY, 380);
    chk("c_state380", b.oState, S_FALL);
    frame();
    chk("c_check", s1, S_CHECK);
    chk("c_y384", y1, 384);
    chk("c_catch", s2, S_CATCH);
    cyc();
    chk("c_spawn", b.oState, S_SPAWN);
    chk("c_score", b.oScore, 1);
    chk("c_valid0", b.oBlockValid, 0);
    cyc();
    chk("c_fall", b.oState, S_FALL);
    chk("c_y0", b.oBlockY, 0);
    chk("c_valid1", b.oBlockValid, 1);

    // Miss: paddle at 464, block spans 224..239, missed at Y=416.
    do_reset();
    b.iPaddleX = 10'd464;
    seeded_start();
    frames(207);
    frame();
    chk("m_check", s1, S_CHECK);
    chk("m_y416", y1, 416);
    chk("m_miss", s2, S_MISS);
    chk("m_lives_in_miss", b.oLives, 3);
    cyc();
    chk("m_spawn", b.oState, S_SPAWN);
    chk("m_lives2", b.oLives, 2);
    b.iPaddleX = 10'd0;
    cyc();
    frames(208);
    chk("m2_miss", b.oState, S_MISS);
    cyc();
    chk("m2_lives1", b.oLives, 1);
    cyc();
    frames(208);
    chk("m3_miss", b.oState, S_MISS);
    cyc();
    chk("ov_state", b.oState, S_OVER);
    chk("ov_lives", b.oLives, 0);
    chk("ov_flag", b.oGameOver, 1);
    chk("ov_valid", b.oBlockValid, 0);
    frame();
    chk("ov_tick_drop", s2, S_OVER);
    b.iStart = 1'b1;
    cyc();
    b.iStart = 1'b0;
    chk("rs_state", b.oState, S_SPAWN);
    chk("rs_lives", b.oLives, 3);
    chk("rs_score", b.oScore, 0);
    chk("rs_over", b.oGameOver, 0);

    // Asynchronous reset mid-fall at Y=100.
    cyc();
    frames(50);
    chk("ar_y100", b.oBlockY, 100);
    chk("ar_fall", b.oState, S_FALL);
    #2 Reset = 1'b1;
    #1 chk_reset_vals("ar");
    cyc();
    Reset = 1'b0;

    // Score saturation on the fast-catch instance.
    b2.iStart = 1'b1;
    cyc();
    b2.iStart = 1'b0;
    k = 0;
    while (b2.oScore != 8'd255 && k < 10000) begin
      cyc();
      k++;
    end
    chk("sat_reach", 32'(k < 10000), 1);
    chk("sat_lives", b2.oLives, 3);
    k = 0;
    while (b2.oState != 3'(S_CATCH) && k < 100) begin
      cyc();
      k++;
    end
    chk("sat_catch_seen", 32'(k < 100), 1);
    cyc();
    chk("sat_spawn", b2.oState, S_SPAWN);
    chk("sat_255", b2.oScore, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/catch_game_scheduler.md
Name: catch_game_scheduler

Overview:
Frame-rate game sequencer that sits between the PS2 paddle logic and the VGA controller. It detects each frame boundary from the VGA vertical sync and steps a falling 16x16 block down the screen. It checks the block against the paddle position (paddle X from the PS2 controller) and keeps score and lives. Its outputs drive the block overlay in the pixel-colour mux and the score/lives display.

Parameters:
FRAMES_PER_STEP, 2, frames between block position updates (>=1)
STEP, 4, pixels added to block Y per update
PADDLE_Y, 400, paddle top line, active-area Y coordinate
FLOOR_Y, 416, block Y at or beyond which the block is missed
BLOCK_W, 16, block width and height in pixels
PADDLE_W, 48, paddle width in pixels
X_MIN, 224, leftmost block X (equals paddle reset X, 28*8)
LIVES, 3, lives at game start (1..7)

Ports:
Clock  in  1  25 MHz pixel clock
Reset  in  1  asynchronous, active-high
iVSync  in  1  VGA vertical sync, active-low level
iStart  in  1  start/restart request, level, sampled each clock
iPaddleX  in  10  paddle left X, same units as oBlockX
oBlockX  out  10  block left X
oBlockY  out  10  block top Y
oBlockValid  out  1  block should be drawn
oScore  out  8  catches, saturating
oLives  out  3  remaining lives
oGameOver  out  1  high in OVER state
oState  out  3  state encoding, for debug/LEDs

Behaviour:
- Reset value of Reset is decided: Reset, asynchronous, active-high; clock is Clock.
- Reset values: state IDLE, oBlockX=X_MIN, oBlockY=0, oBlockValid=0, oScore=0, oLives=LIVES, oGameOver=0, frame counter=0, LFSR=8'hA5, registered iVSync=1.
- Frame tick: iVSync is registered once. tick = prev & ~iVSync, i.e. a 1->0 edge. The tick is a one-cycle pulse.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It steps every clock in all states except during Reset. It is never zero.
- States: IDLE=0, SPAWN=1, FALL=2, CHECK=3, CATCH=4, MISS=5, OVER=6.
- IDLE: oBlockValid=0. If iStart=1, go to SPAWN and load oScore=0, oLives=LIVES.
- SPAWN (1 cycle):
  - oBlockX = X_MIN + {LFSR[4:0],3'b000}, giving a range of X_MIN..X_MIN+248.
  - oBlockY=0, frame counter=0, oBlockValid=1.
  - Next state is FALL.
- FALL:
  - On tick with counter < FRAMES_PER_STEP-1: counter+1.
  - On tick with counter == FRAMES_PER_STEP-1: counter=0, oBlockY += STEP, next state CHECK.
  - Without a tick, FALL holds.
- CHECK (1 cycle): iPaddleX is sampled in this cycle.
  - hit = (oBlockY+BLOCK_W >= PADDLE_Y) && (oBlockX+BLOCK_W > iPaddleX) && (oBlockX < iPaddleX+PADDLE_W).
  - All compares use 11-bit zero-extended unsigned arithmetic, with no wrap.
  - hit -> CATCH; else oBlockY >= FLOOR_Y -> MISS; else -> FALL.
- CATCH (1 cycle): oScore+1, saturating at 255. oBlockValid=0. Next state SPAWN.
- MISS (1 cycle): oBlockValid=0. If oLives==1: oLives=0, go to OVER. Else oLives-1, go to SPAWN.
- OVER: oGameOver=1, oBlockValid=0. Score and lives are held. iStart=1 goes to SPAWN and reloads oScore=0, oLives=LIVES. oGameOver=0 from that edge.
- iStart is ignored in SPAWN, FALL, CHECK, CATCH and MISS.
- A tick arriving in a non-FALL state is dropped. It does not advance the counter.
- Outputs are all registered; none is combinational from inputs.
- Reset mid-game returns immediately (asynchronously) to the reset values. No catch or miss is credited.
- Unused state codes (7) go to IDLE on the next clock.

Test Plan:
- Reset, then iStart held 1 cycle -> SPAWN then FALL. oLives=3, oScore=0, oBlockY=0, oBlockValid=1. oBlockX equals X_MIN + 8*LFSR[4:0] from the SPAWN cycle.
- Generate 6 VSync falling edges in FALL with FRAMES_PER_STEP=2 -> oBlockY=12 after the 6th edge. Each update is followed by exactly one CHECK cycle, then FALL.
- Force oBlockX=224 via a seeded spawn, iPaddleX=224, run frames -> CATCH when oBlockY reaches 384. oScore=1, then SPAWN follows with oBlockY=0.
- Same setup with iPaddleX=464 (no overlap: 240 <= 464) -> MISS when oBlockY=416. oLives 3->2, then SPAWN.
- Three consecutive misses -> OVER with oLives=0, oGameOver=1, oBlockValid=0. Then iStart -> oLives=3, oScore=0, oGameOver=0.
- Assert Reset asynchronously mid-FALL (oBlockY=100) -> all outputs return to reset values within the same cycle. Score 255 plus a catch -> stays 255.
